// File: rtl/timer_pkg.sv
// timer_pkg: shared states, modes and prescaler width for the interval timer
package timer_pkg;
  typedef enum logic [1:0] {IDLE, RUN, PAUSED, DONE} timer_state_e;
  typedef enum logic {ONESHOT = 1'b0, PERIODIC = 1'b1} timer_mode_e;
  localparam int PRESCALE_W = 8;
endpackage

// File: rtl/timer_prescaler.sv
// timer_prescaler: strobes en once every limit+1 running cycles
module timer_prescaler
  import timer_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  run,
  input  logic [PRESCALE_W-1:0] limit,
  output logic                  en
);
  logic [PRESCALE_W-1:0] cnt;
  assign en = run && cnt == limit;
  always_ff @(posedge clk) begin
    if (rst || clr) cnt <= '0;
    else if (run) cnt <= en ? '0 : cnt + 1'b1;
  end
endmodule

// File: rtl/interval_timer_ctrl.sv
// interval_timer_ctrl: programmable periodic/one-shot interval timer with config handshake
// Define TIMER_PRESCALE_EN to add the cfg_prescale input and the count prescaler.
module interval_timer_ctrl
  import timer_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [WIDTH-1:0]      cfg_period,
  input  logic                  cfg_periodic,
`ifdef TIMER_PRESCALE_EN
  input  logic [PRESCALE_W-1:0] cfg_prescale,
`endif
  input  logic                  start,
  input  logic                  stop,
  input  logic                  pause,
  output logic                  busy,
  output logic [WIDTH-1:0]      count,
  output logic                  tick,
  output logic                  done,
  output logic [WIDTH-1:0]      tick_count
);
  timer_state_e state, state_d;
  timer_mode_e mode_q;
  logic [WIDTH-1:0] period_q;
  logic hs, go, run, en, term;
  assign cfg_ready = state == IDLE || state == DONE;
  assign busy = !cfg_ready;
  assign hs = cfg_valid && cfg_ready;
  assign go = start && cfg_ready;
  assign run = state == RUN && !stop && !pause;
  assign term = run && en && count == period_q;
`ifdef TIMER_PRESCALE_EN
  logic [PRESCALE_W-1:0] prescale_q;
  timer_prescaler u_prescaler (
    .clk   (clk),
    .rst   (rst),
    .clr   (go || stop || pause),
    .run   (run),
    .limit (prescale_q),
    .en    (en)
  );
`else
  assign en = 1'b1;
`endif
  always_comb begin
    state_d = go ? RUN
      : busy && stop ? IDLE
      : state == RUN && pause ? PAUSED
      : state == PAUSED && !pause ? RUN
      : term && mode_q == ONESHOT ? DONE
      : state;
  end
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= state_d;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      period_q   <= '0;
      mode_q     <= ONESHOT;
      count      <= '0;
      tick       <= 1'b0;
      done       <= 1'b0;
      tick_count <= '0;
`ifdef TIMER_PRESCALE_EN
      prescale_q <= '0;
`endif
    end else begin
      if (hs) begin
        period_q <= cfg_period;
        mode_q   <= timer_mode_e'(cfg_periodic);
`ifdef TIMER_PRESCALE_EN
        prescale_q <= cfg_prescale;
`endif
      end
      tick       <= term;
      count      <= go || (busy && stop) || term ? '0 : run && en ? count + 1'b1 : count;
      tick_count <= go ? '0 : term ? tick_count + 1'b1 : tick_count;
      done       <= go || hs ? 1'b0 : term && mode_q == ONESHOT ? 1'b1 : done;
    end
  end
endmodule

// File: tb/tb_interval_timer_ctrl.sv
// tb_interval_timer_ctrl: directed steps with a cycle-model scoreboard plus fixed-value checks
module tb_interval_timer_ctrl;
  logic clk = 0, rst = 1, cfg_valid = 0, cfg_periodic = 0, start = 0, stop = 0, pause = 0;
  logic [7:0] cfg_period = 0, cfg_prescale = 0;
  logic cfg_ready, busy, tick, done;
  logic [7:0] count, tick_count;

  interval_timer_ctrl #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_period(cfg_period), .cfg_periodic(cfg_periodic),
`ifdef TIMER_PRESCALE_EN
    .cfg_prescale(cfg_prescale),
`endif
    .start(start), .stop(stop), .pause(pause), .busy(busy), .count(count),
    .tick(tick), .done(done), .tick_count(tick_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {logic busy, ready, done, tick; logic [7:0] count, tc;} obs_t;
  obs_t q[$];
  int checks = 0, fails = 0;
  int ms = 0;
  logic [7:0] mc = 0, mtc = 0, mp = 0, mps = 0, mpc = 0;
  logic mt = 0, md = 0, mm = 0;

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  // Reference behaviour of one clock edge, computed from the inputs about to be sampled
  task automatic model();
    logic ready, hs, go, en, nt, nd, nm;
    logic [7:0] nc, ntc, np, nps, npc;
    int nms;
    if (rst) begin
      ms = 0; mc = 0; mtc = 0; mp = 0; mps = 0; mpc = 0; mt = 0; md = 0; mm = 0;
    end else begin
      ready = ms == 0 || ms == 3;
      hs = cfg_valid && ready;
      go = start && ready;
      en = mpc == mps;
      nms = ms; nc = mc; ntc = mtc; np = mp; nps = mps; npc = mpc; nt = 0; nd = md; nm = mm;
      if (go) begin
        nc = 0; ntc = 0; nd = 0; nms = 1; npc = 0;
      end else if (ms == 1 || ms == 2) begin
        if (stop) begin nms = 0; nc = 0; npc = 0; end
        else if (pause) begin nms = 2; npc = 0; end
        else if (ms == 2) nms = 1;
        else if (!en) npc = mpc + 1;
        else begin
          npc = 0;
          if (mc == mp) begin
            nc = 0; nt = 1; ntc = mtc + 1;
            if (!mm) begin nms = 3; nd = 1; end
          end else nc = mc + 1;
        end
      end
      if (hs) begin
        np = cfg_period; nm = cfg_periodic; nd = 0;
`ifdef TIMER_PRESCALE_EN
        nps = cfg_prescale;
`endif
      end
      ms = nms; mc = nc; mtc = ntc; mp = np; mps = nps; mpc = npc; mt = nt; md = nd; mm = nm;
    end
    q.push_back({ms == 1 || ms == 2, !(ms == 1 || ms == 2), md, mt, mc, mtc});
  endtask

  task automatic step(input logic cv, input logic [7:0] cp, input logic cm,
                      input logic st, input logic sp, input logic pa);
    obs_t e, g;
    cfg_valid = cv; cfg_period = cp; cfg_periodic = cm; start = st; stop = sp; pause = pa;
    model();
    @(posedge clk);
    #1;
    e = q.pop_front();
    g = {busy, cfg_ready, done, tick, count, tick_count};
    chk("scoreboard", 32'(g), 32'(e));
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1;
    idle(2);
    chk("rst_busy", busy, 0); chk("rst_ready", cfg_ready, 1); chk("rst_count", count, 0);
    chk("rst_tick", tick, 0); chk("rst_done", done, 0); chk("rst_tc", tick_count, 0);
    rst = 0;
    // periodic P=3
    step(1, 3, 1, 1, 0, 0);
    chk("per_count0", count, 0);
    for (int i = 2; i <= 13; i++) begin
      idle(1);
      chk("per_tick", tick, i % 4 == 1);
      chk("per_count", count, (i - 1) % 4);
      chk("per_busy", busy, 1);
      chk("per_ready", cfg_ready, 0);
    end
    chk("per_tc", tick_count, 3);
    step(0, 0, 0, 0, 1, 0);
    chk("per_stop_busy", busy, 0); chk("per_stop_tc", tick_count, 3);
    // one-shot P=2
    step(1, 2, 0, 1, 0, 0);
    idle(2);
    chk("os_count2", count, 2); chk("os_done_early", done, 0);
    idle(1);
    chk("os_tick", tick, 1); chk("os_done", done, 1); chk("os_busy", busy, 0);
    chk("os_count", count, 0); chk("os_tc", tick_count, 1);
    idle(3);
    chk("os_hold_done", done, 1); chk("os_hold_tick", tick, 0); chk("os_hold_count", count, 0);
    step(0, 0, 0, 0, 1, 0);
    chk("os_stop_in_done", done, 1);
    step(0, 0, 0, 1, 0, 0);
    chk("os_restart_done", done, 0); chk("os_restart_busy", busy, 1);
    idle(3);
    chk("os_rerun_done", done, 1); chk("os_rerun_tc", tick_count, 1);
    step(1, 9, 1, 0, 0, 0);
    chk("os_cfg_clears_done", done, 0); chk("os_cfg_stays", cfg_ready, 1);
    // pause / stop P=5
    step(1, 5, 1, 1, 0, 0);
    idle(2);
    chk("pz_count2", count, 2);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 0, 0, 1);
      chk("pz_hold", count, 2); chk("pz_tick", tick, 0); chk("pz_busy", busy, 1);
    end
    idle(1);
    chk("pz_resume_edge", count, 2);
    idle(1);
    chk("pz_resume3", count, 3);
    idle(1);
    step(0, 0, 0, 0, 1, 0);
    chk("pz_stop_busy", busy, 0); chk("pz_stop_count", count, 0);
    // stop colliding with terminal count, P=1
    step(1, 1, 1, 1, 0, 0);
    idle(1);
    chk("col_count1", count, 1);
    step(0, 0, 0, 0, 1, 0);
    chk("col_tick", tick, 0); chk("col_busy", busy, 0); chk("col_tc", tick_count, 0);
    // config together with start, P=7
    step(1, 7, 1, 1, 0, 0);
    for (int i = 1; i <= 8; i++) begin
      idle(1);
      chk("p7_tick", tick, i == 8);
    end
    step(0, 0, 0, 0, 1, 0);
    // P=0
    step(1, 0, 1, 1, 0, 0);
    chk("p0_start_tick", tick, 0);
    for (int i = 0; i < 5; i++) begin
      idle(1);
      chk("p0_tick", tick, 1);
    end
    chk("p0_tc", tick_count, 5);
    step(0, 0, 0, 0, 1, 0);
    // P=255, then config attempt during RUN is ignored
    step(1, 255, 1, 1, 0, 0);
    for (int i = 1; i <= 256; i++) begin
      idle(1);
      chk("p255_tick", tick, i == 256);
      if (i == 255) chk("p255_count", count, 255);
    end
    chk("run_ready", cfg_ready, 0);
    step(1, 3, 0, 0, 0, 0);
    chk("run_cfg_ready", cfg_ready, 0);
    for (int i = 1; i <= 255; i++) begin
      idle(1);
      chk("run_cfg_ignored", tick, i == 255);
    end
    chk("run_cfg_busy", busy, 1);
    step(0, 0, 0, 0, 1, 0);
    // tick_count wrap
    step(1, 0, 1, 1, 0, 0);
    for (int i = 1; i <= 256; i++) begin
      idle(1);
      if (i == 255) chk("wrap_tc255", tick_count, 255);
    end
    chk("wrap_tc0", tick_count, 0); chk("wrap_tick", tick, 1);
    step(0, 0, 0, 0, 1, 0);
    // reset mid-run restores period 0 / one-shot
    step(1, 4, 1, 1, 0, 0);
    idle(2);
    rst = 1;
    idle(1);
    rst = 0;
    chk("mrst_busy", busy, 0); chk("mrst_count", count, 0); chk("mrst_tc", tick_count, 0);
    step(0, 0, 0, 1, 0, 0);
    idle(1);
    chk("mrst_tick", tick, 1); chk("mrst_done", done, 1); chk("mrst_busy2", busy, 0);
`ifdef TIMER_PRESCALE_EN
    cfg_prescale = 2;
    step(1, 1, 1, 1, 0, 0);
    cfg_prescale = 0;
    for (int i = 1; i <= 12; i++) begin
      idle(1);
      chk("pre_tick", tick, i % 6 == 0);
    end
    step(0, 0, 0, 0, 1, 0);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
